// File: rtl/add_round_key_stage_if.sv
// rtl/add_round_key_stage_if.sv - handshake and data bundle for the AddRoundKey stage
interface add_round_key_stage_if;
  logic         s_valid;
  logic         s_ready;
  logic         s_first;
  logic [127:0] s_mc_state;
  logic [127:0] s_byp_state;
  logic [127:0] s_key;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_state;
  logic [3:0]   m_round;
  logic         m_last;
  logic [15:0]  m_parity;
  logic         err;

  // Environment side: drives upstream states and downstream ready.
  modport master (
    output s_valid, s_first, s_mc_state, s_byp_state, s_key, m_ready,
    input  s_ready, m_valid, m_state, m_round, m_last, m_parity, err
  );

  // Stage side.
  modport slave (
    input  s_valid, s_first, s_mc_state, s_byp_state, s_key, m_ready,
    output s_ready, m_valid, m_state, m_round, m_last, m_parity, err
  );
endinterface

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - AES AddRoundKey stage with round tagging and 2-entry output FIFO; optional byte parity under ARK_PARITY_EN
module add_round_key_stage #(
  parameter int NR = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  add_round_key_stage_if.slave bus
);

  localparam logic [3:0] NR_TAG = 4'(NR);

  logic [1:0]   occ_q, occ_d;
  logic [127:0] state_q [2];
  logic [127:0] state_d [2];
  logic [3:0]   round_q [2];
  logic [3:0]   round_d [2];
  logic [3:0]   rnd_q, rnd_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  logic         push, pop;
  logic         ld0, ld0_from1, ld1;
  logic [3:0]   tag;
  logic [127:0] result;

  // Ready depends only on stored occupancy, so no path from m_ready or s_valid.
  assign bus.s_ready = (occ_q != 2'd2);
  assign bus.m_valid = (occ_q != 2'd0);
  assign push        = bus.s_valid & bus.s_ready;
  assign pop         = bus.m_valid & bus.m_ready;

  // Round 0 (whitening) and the final round skip MixColumns.
  assign tag    = bus.s_first ? 4'd0 : rnd_q;
  assign result = ((tag == 4'd0) || (tag == NR_TAG)) ? (bus.s_byp_state ^ bus.s_key)
                                                     : (bus.s_mc_state ^ bus.s_key);

  assign bus.m_state = state_q[0];
  assign bus.m_round = round_q[0];
  assign bus.m_last  = (round_q[0] == NR_TAG);
  assign bus.err     = err_q;

  // Round counter and sticky sequencing error; wrap_q marks that rnd returned to 0 via round NR.
  always_comb begin
    rnd_d  = rnd_q;
    wrap_d = wrap_q;
    err_d  = err_q;
    if (push) begin
      rnd_d  = (tag == NR_TAG) ? 4'd0 : tag + 4'd1;
      wrap_d = (tag == NR_TAG);
      if (bus.s_first && (rnd_q != 4'd0)) err_d = 1'b1;
      if (!bus.s_first && (rnd_q == 4'd0) && wrap_q) err_d = 1'b1;
    end
  end

  // FIFO control: slot 0 is the head; a push with a simultaneous pop at occupancy 1 lands in the head.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + 2'd1;
    if (pop && !push) occ_d = occ_q - 2'd1;
    ld0_from1  = (occ_q == 2'd2);
    ld0        = (push && ((occ_q == 2'd0) || pop)) || (pop && (occ_q == 2'd2));
    ld1        = push && !pop && (occ_q == 2'd1);
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    round_d[0] = round_q[0];
    round_d[1] = round_q[1];
    if (ld0) begin
      state_d[0] = ld0_from1 ? state_q[1] : result;
      round_d[0] = ld0_from1 ? round_q[1] : tag;
    end
    if (ld1) begin
      state_d[1] = result;
      round_d[1] = tag;
    end
  end

  // Control and data registers; reset empties the FIFO and zeroes the visible head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      rnd_q  <= 4'd0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= '0;
        round_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      rnd_q  <= rnd_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        round_q[i] <= round_d[i];
      end
    end
  end

`ifdef ARK_PARITY_EN
  logic [15:0] par_q [2];
  logic [15:0] par_d [2];
  logic [15:0] result_par;

  // Even parity per byte travels with each result through the FIFO.
  always_comb begin
    for (int i = 0; i < 16; i++) result_par[i] = ^result[8*i +: 8];
    par_d[0] = par_q[0];
    par_d[1] = par_q[1];
    if (ld0) par_d[0] = ld0_from1 ? par_q[1] : result_par;
    if (ld1) par_d[1] = result_par;
  end

  // Parity storage alongside the state slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q[0] <= '0;
      par_q[1] <= '0;
    end else begin
      par_q[0] <= par_d[0];
      par_q[1] <= par_d[1];
    end
  end

  assign bus.m_parity = par_q[0];
`else
  assign bus.m_parity = 16'h0000;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - self-checking bench for add_round_key_stage
module tb_add_round_key_stage;
  localparam int NR = 10;

  typedef struct {
    logic         first;
    logic [127:0] mc;
    logic [127:0] byp;
    logic [127:0] key;
    logic [127:0] exp_state;
    logic [3:0]   exp_round;
    logic         exp_last;
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  add_round_key_stage_if bus();
  add_round_key_stage #(.NR(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_par(input logic [127:0] s);
    logic [15:0] p;
    p = '0;
    for (int b = 0; b < 16; b++) p[b] = (($countones(s[8*b +: 8]) % 2) == 1);
`ifdef ARK_PARITY_EN
    return p;
`else
    return p & 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [127:0] mc,
                       input logic [127:0] byp, input logic [127:0] key);
    bus.s_valid     = v;
    bus.s_first     = f;
    bus.s_mc_state  = mc;
    bus.s_byp_state = byp;
    bus.s_key       = key;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    vec_t         vecs [11];
    exp_t         q [$];
    exp_t         e;
    logic [127:0] a_st, b_st, mc, byp, key;
    int           mrnd, tag;
    bit           seen_nr, merr, sv, mr, first, acc;

    drive(0, 0, '0, '0, '0);
    bus.m_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_state", bus.m_state, 0);
    check("rst_m_round", bus.m_round, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_parity", bus.m_parity, 0);
    check("rst_err", bus.err, 0);
    step();
    step();
    rst_n = 1'b1;

    // Vector table: a full AES-128 sequence, round 0 is the known-answer vector.
    for (int i = 0; i < 11; i++) begin
      vecs[i].first     = (i == 0);
      vecs[i].mc        = rnd128();
      vecs[i].byp       = rnd128();
      vecs[i].key       = rnd128();
      vecs[i].exp_round = 4'(i);
      vecs[i].exp_last  = (i == NR);
    end
    vecs[0].byp = 128'h00112233445566778899aabbccddeeff;
    vecs[0].key = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[0].exp_state = 128'h00102030405060708090a0b0c0d0e0f0;
    for (int i = 1; i < 11; i++)
      vecs[i].exp_state = (i == NR) ? (vecs[i].byp ^ vecs[i].key) : (vecs[i].mc ^ vecs[i].key);

    bus.m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1, vecs[i].first, vecs[i].mc, vecs[i].byp, vecs[i].key);
      check($sformatf("vec%0d_s_ready", i), bus.s_ready, 1);
      step();
      check($sformatf("vec%0d_m_valid", i), bus.m_valid, 1);
      check($sformatf("vec%0d_m_state", i), bus.m_state, vecs[i].exp_state);
      check($sformatf("vec%0d_m_round", i), bus.m_round, vecs[i].exp_round);
      check($sformatf("vec%0d_m_last", i), bus.m_last, vecs[i].exp_last);
      check($sformatf("vec%0d_m_parity", i), bus.m_parity, exp_par(vecs[i].exp_state));
      check($sformatf("vec%0d_err", i), bus.err, 0);
    end
    drive(0, 0, '0, '0, '0);
    step();
    check("seq_drain_m_valid", bus.m_valid, 0);

    // Backpressure: two accepted, third refused, head held stable.
    bus.m_ready = 1'b0;
    byp = rnd128(); key = rnd128();
    a_st = byp ^ key;
    drive(1, 1, rnd128(), byp, key);
    step();
    mc = rnd128(); key = rnd128();
    b_st = mc ^ key;
    drive(1, 0, mc, rnd128(), key);
    check("bp_s_ready_2nd", bus.s_ready, 1);
    step();
    check("bp_head_a", bus.m_state, a_st);
    drive(1, 0, rnd128(), rnd128(), rnd128());
    check("bp_s_ready_full", bus.s_ready, 0);
    step();
    check("bp_s_ready_held", bus.s_ready, 0);
    check("bp_head_stable", bus.m_state, a_st);
    check("bp_round_stable", bus.m_round, 0);
    drive(0, 0, '0, '0, '0);
    bus.m_ready = 1'b1;
    step();
    check("bp_pop_b", bus.m_state, b_st);
    check("bp_pop_b_round", bus.m_round, 1);
    check("bp_s_ready_back", bus.s_ready, 1);
    step();
    check("bp_empty", bus.m_valid, 0);

    // Restart mid-sequence: rnd is 2, advance to 4 then inject s_first.
    for (int j = 2; j < 4; j++) begin
      drive(1, 0, rnd128(), rnd128(), rnd128());
      step();
      check($sformatf("mid_round%0d", j), bus.m_round, 4'(j));
    end
    check("mid_err_clean", bus.err, 0);
    drive(1, 1, rnd128(), rnd128(), rnd128());
    step();
    check("restart_round0", bus.m_round, 0);
    check("restart_err", bus.err, 1);
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, rnd128(), rnd128(), rnd128());
      step();
      check($sformatf("err_sticky%0d", j), bus.err, 1);
    end
    drive(0, 0, '0, '0, '0);
    step();

    // Asynchronous reset with two entries buffered.
    bus.m_ready = 1'b0;
    drive(1, 1, rnd128(), rnd128(), rnd128());
    step();
    drive(1, 0, rnd128(), rnd128(), rnd128());
    step();
    check("prerst_full", bus.s_ready, 0);
    drive(0, 0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_s_ready", bus.s_ready, 1);
    check("midrst_m_state", bus.m_state, 0);
    check("midrst_m_round", bus.m_round, 0);
    check("midrst_m_last", bus.m_last, 0);
    check("midrst_m_parity", bus.m_parity, 0);
    check("midrst_err", bus.err, 0);
    step();
    rst_n = 1'b1;

    // Parity on a byte of 8'h07.
    bus.m_ready = 1'b1;
    drive(1, 1, rnd128(), 128'h07, '0);
    step();
    check("par07_round", bus.m_round, 0);
    check("par07_state", bus.m_state, 128'h07);
`ifdef ARK_PARITY_EN
    check("par07_parity", bus.m_parity, 16'h0001);
`else
    check("par07_parity", bus.m_parity, 16'h0000);
`endif
    drive(0, 0, '0, '0, '0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Random traffic against a queue-based reference.
    mrnd = 0; seen_nr = 0; merr = 0;
    for (int c = 0; c < 600; c++) begin
      check("rnd_s_ready", bus.s_ready, (q.size() < 2));
      check("rnd_m_valid", bus.m_valid, (q.size() > 0));
      if (q.size() > 0) begin
        e = q[0];
        check("rnd_m_state", bus.m_state, e.st);
        check("rnd_m_round", bus.m_round, e.rd);
        check("rnd_m_last", bus.m_last, (int'(e.rd) == NR));
        check("rnd_m_parity", bus.m_parity, exp_par(e.st));
      end
      check("rnd_err", bus.err, merr);

      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      first = (mrnd == 0);
      if ($urandom_range(0, 39) == 0) first = !first;
      mc = rnd128(); byp = rnd128(); key = rnd128();
      drive(sv, first, mc, byp, key);
      bus.m_ready = mr;

      acc = sv && (q.size() < 2);
      if (mr && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        tag = first ? 0 : mrnd;
        e.st = (tag == 0 || tag == NR) ? (byp ^ key) : (mc ^ key);
        e.rd = 4'(tag);
        q.push_back(e);
        if (first && mrnd != 0) merr = 1;
        if (!first && mrnd == 0 && seen_nr) merr = 1;
        if (tag == NR) seen_nr = 1;
        mrnd = (tag == NR) ? 0 : tag + 1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of the final cipher round (10/12/14 for AES-128/192/256).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port s_valid, input, 1, upstream state words valid.
REQ-005 The block SHALL have port s_ready, output, 1, block can accept a state this cycle.
REQ-006 The block SHALL have port s_first, input, 1, accepted state is round 0 (plaintext); restarts the round count.
REQ-007 The block SHALL have port s_mc_state, input, 128, post-MixColumns state from the MixColumns stage.
REQ-008 The block SHALL have port s_byp_state, input, 128, state that skips MixColumns (plaintext in round 0, ShiftRows output in round NR).
REQ-009 The block SHALL have port s_key, input, 128, round key for the accepted state.
REQ-010 The block SHALL have port m_valid, output, 1, output state valid.
REQ-011 The block SHALL have port m_ready, input, 1, downstream accepts output.
REQ-012 The block SHALL have port m_state, output, 128, state after AddRoundKey.
REQ-013 The block SHALL have port m_round, output, 4, round index tagged to m_state.
REQ-014 The block SHALL have port m_last, output, 1, m_round equals NR (m_state is ciphertext).
REQ-015 The block SHALL have port m_parity, output, 16, even parity per byte of m_state, bit i covering m_state[8i+7:8i].
REQ-016 The block SHALL have port err, output, 1, sticky sequencing error.

Function
REQ-017 The block SHALL accept a state when s_valid and s_ready are both high at a rising clk edge, and transfer output when m_valid and m_ready are both high.
REQ-018 The block SHALL store results in a 2-entry FIFO; s_ready = (occupancy < 2), derived from registers only, with no combinational path from m_ready or s_valid.
REQ-019 The block SHALL keep an internal round counter rnd (0..NR); on accept the tag is 0 if s_first, else rnd; next rnd = tag+1, wrapping to 0 after tag NR.
REQ-020 The block SHALL compute result = s_byp_state ^ s_key for tags 0 and NR, else s_mc_state ^ s_key, bitwise over 128 bits.
REQ-021 Latency SHALL be one cycle: a state accepted at edge N into an empty FIFO drives m_valid=1 with its result after edge N.
REQ-022 Output order SHALL equal accept order; m_state/m_round/m_last/m_parity SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 With occupancy 1 and simultaneous push and pop, occupancy SHALL stay 1 and the new entry SHALL appear at the head next cycle.
REQ-024 The block SHALL set err when s_first is accepted while rnd != 0, or when a state without s_first is accepted while rnd = 0 after a prior round NR; the accept still proceeds per REQ-019.
REQ-025 err SHALL remain 1 until reset.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear FIFO occupancy, rnd, and err, and drive m_valid=0, m_state=0, m_round=0, m_last=0, m_parity=0.
REQ-027 s_ready SHALL be 1 during and after reset; reset mid-operation SHALL discard all buffered states.

Configuration
REQ-028 With macro ARK_PARITY_EN defined, m_parity SHALL be computed per REQ-015 and stored in the FIFO with each result.
REQ-029 Without ARK_PARITY_EN, m_parity SHALL be tied to 16'h0000 and no parity storage SHALL be built.

Verification
REQ-030 s_first=1, s_byp_state=00112233445566778899aabbccddeeff, s_key=000102030405060708090a0b0c0d0e0f -> next cycle m_valid=1, m_state=00102030405060708090a0b0c0d0e0f0, m_round=0, m_last=0.
REQ-031 Eleven back-to-back accepts (first with s_first), m_ready=1 -> m_round 0..10 in order, mc path used for rounds 1..9 only, m_last=1 only on round 10, err=0.
REQ-032 m_ready=0, three s_valid cycles -> two accepted, s_ready=0 on third, head stays stable; m_ready=1 -> both emerge in order, s_ready returns to 1.
REQ-033 s_first=1 accepted while rnd=4 -> output m_round=0, err=1 and stays 1 through later traffic.
REQ-034 rst_n pulsed low with two entries buffered -> m_valid=0, s_ready=1, all outputs 0 immediately; next s_first block tags round 0.
REQ-035 ARK_PARITY_EN defined, m_state byte 8'h07 -> corresponding m_parity bit 1; undefined -> m_parity=16'h0000.
